pcie_irq_scheduler: RTL and testbench
=====================================

# pcie_irq_scheduler

Collects interrupt events from up to NUM_SRC user-logic sources and sequences them onto the single interrupt request/acknowledge handshake of the PCIe endpoint core. Only one interrupt is outstanding at a time, and sources are granted round-robin. The block sits in the user clock domain beside the PCIe block design, between the application logic and the core's interrupt port. An optional watchdog recovers from a request that is never acknowledged.

## Interface
- NUM_SRC, 4: number of interrupt sources (2..32).
- VEC_W, $clog2(NUM_SRC): width of the vector number.
- TIMEOUT, 1024: cycles to wait for an acknowledge before abandoning a request (≥4). Used only with the watchdog compiled in.

Ports:
- axi_aclk  in  1  user clock from the PCIe core; all logic is on its rising edge.
- axi_aresetn  in  1  asynchronous, active-low reset.
- src_irq  in  NUM_SRC  per-source event line, synchronous to axi_aclk; a rising edge is one event.
- irq_mask  in  NUM_SRC  1 = source is not arbitrated. Its events still latch into pending.
- msi_enable  in  1  core reports MSI enabled; new requests start only while high.
- msi_req  out  1  interrupt request to the core.
- msi_num  out  VEC_W  vector number of the request; stable while msi_req is high.
- msi_ack  in  1  one-cycle acknowledge from the core.
- pending  out  NUM_SRC  latched, not-yet-delivered events.
- timeout_err  out  1  sticky: a request was abandoned.
- err_clr  in  1  clears timeout_err.

## Operation
- Edge detect: src_q is src_irq registered. rise = src_irq & ~src_q, and it sets the matching pending bit. Reset value of src_q is 0, so a line already high when reset releases produces an event.
- Eligible set: pending & ~irq_mask.
- Round-robin: rr_ptr (VEC_W bits, reset 0). The winner is the first eligible index at or above rr_ptr, wrapping to 0.
- FSM states: IDLE, REQ, GAP.
  - IDLE: if msi_enable=1 and the eligible set is non-zero, register the winner into msi_num, set msi_req=1, and go to REQ.
  - REQ: msi_req holds high and msi_num is frozen. Changes to msi_enable or irq_mask are ignored here; a request is never withdrawn except by the watchdog.
    - On msi_ack: clear pending[msi_num], set rr_ptr = msi_num+1 (wrapping NUM_SRC-1 → 0), set msi_req=0, go to GAP.
    - If a new rise on the same source arrives in the ack cycle, the set wins and pending stays 1.
  - GAP: one cycle with msi_req=0, then go to IDLE. This guarantees msi_req is low for at least one cycle between requests.
- msi_ack while not in REQ is ignored.
- Multiple events on one source before delivery collapse into one interrupt.
- Reset mid-operation: all state clears immediately and msi_req drops asynchronously. Any request in flight is lost.
- Reset values: msi_req=0, msi_num=0, pending=0, timeout_err=0, FSM in IDLE, rr_ptr=0, watchdog counter=0.

## Timing
- Rise sampled at edge N → pending bit visible after edge N → msi_req high after edge N+1, if IDLE and eligible.
- Ack sampled at edge M → msi_req low and pending cleared after edge M → earliest next msi_req after edge M+2.
- Best-case throughput: one interrupt every 3 cycles when msi_ack is returned in the first REQ cycle.
- timeout_err: set has priority over err_clr in the same cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- PCIE_IRQ_TIMEOUT_EN defined: a counter runs in REQ.
  - It resets on entry to REQ and counts each REQ cycle with no ack.
  - When it reaches TIMEOUT-1 with no ack: msi_req drops, timeout_err is set, pending[msi_num] stays set, rr_ptr = msi_num+1, go to GAP.
  - An ack in the terminal cycle counts as a normal ack, with no error.
- PCIE_IRQ_TIMEOUT_EN not defined: there is no counter and REQ waits indefinitely. timeout_err is tied to 0 and err_clr is unused.

## Test plan
- Single event: NUM_SRC=4, pulse src_irq[2] at cycle 10, msi_enable=1, ack 3 cycles after msi_req → msi_req rises after cycle 11 with msi_num=2; pending returns to 0 after the ack; msi_req low the cycle after the ack.
- Round-robin: rises on src 0, 1, 3 in the same cycle, immediate acks → grants in order 0, 1, 3, spaced 3 cycles apart; then a new rise on src 0 with src 3 also pending and rr_ptr=0 → grants 0 then 3.
- Mask and enable: src 1 masked, then events on src 1 and src 2 → only 2 is delivered and pending=0b0010 remains; unmask → vector 1 is delivered. With msi_enable=0 → no msi_req; raise msi_enable → request within 1 cycle.
- Collision: a rise on src 3 in the same cycle as msi_ack for vector 3 → pending[3] stays 1 and vector 3 is requested again after GAP.
- Watchdog (macro defined, TIMEOUT=16): never ack → msi_req high for exactly 16 cycles, then low, timeout_err=1, pending bit still set; the next grant goes to the next eligible source. Pulse err_clr → timeout_err=0. Same stimulus without the macro → msi_req stays high indefinitely.
- Reset mid-request: assert axi_aresetn=0 while msi_req=1 → msi_req, pending and timeout_err read 0 before the next clock edge; after release, an idle input produces no request.

Source files
------------

// File: rtl/pcie_irq_scheduler_if.sv
// pcie_irq_scheduler_if
// Interrupt handshake between the scheduler and the PCIe endpoint core.
//   msi_req    : interrupt request (scheduler -> core)
//   msi_num    : vector number, stable while msi_req is high (scheduler -> core)
//   msi_ack    : one-cycle acknowledge (core -> scheduler)
//   msi_enable : core reports MSI enabled (core -> scheduler)
// Modports: master = scheduler side, slave = core side.
interface pcie_irq_scheduler_if #(
    parameter int VEC_W = 2
);
    logic             msi_req;
    logic [VEC_W-1:0] msi_num;
    logic             msi_ack;
    logic             msi_enable;

    modport master (
        output msi_req,
        output msi_num,
        input  msi_ack,
        input  msi_enable
    );

    modport slave (
        input  msi_req,
        input  msi_num,
        output msi_ack,
        output msi_enable
    );
endinterface

// File: rtl/pcie_irq_scheduler.sv
// pcie_irq_scheduler
// Latches rising-edge interrupt events from NUM_SRC sources and delivers
// them one at a time, round-robin, over the PCIe core's req/ack interrupt
// handshake. Only one request is outstanding; msi_req is low for at least
// one cycle between requests.
//
// Ports:
//   axi_aclk    : user clock, all logic on the rising edge
//   axi_aresetn : asynchronous active-low reset
//   src_irq     : per-source event lines, rising edge = one event
//   irq_mask    : 1 = source excluded from arbitration (events still latch)
//   msi         : handshake interface (master side: msi_req/msi_num out,
//                 msi_ack/msi_enable in)
//   pending     : latched, not-yet-delivered events
//   timeout_err : sticky, a request was abandoned by the watchdog
//   err_clr     : clears timeout_err (set wins in the same cycle)
//
// Optional feature: define PCIE_IRQ_TIMEOUT_EN to build the acknowledge
// watchdog. Without it REQ waits forever and timeout_err is constant 0.
module pcie_irq_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int VEC_W   = $clog2(NUM_SRC),
    parameter int TIMEOUT = 1024
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic [NUM_SRC-1:0]   src_irq,
    input  logic [NUM_SRC-1:0]   irq_mask,
    pcie_irq_scheduler_if.master msi,
    output logic [NUM_SRC-1:0]   pending,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [NUM_SRC-1:0] src_q_reg;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic [VEC_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic               msi_req_reg, msi_req_next;
    logic [VEC_W-1:0]   msi_num_reg, msi_num_next;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] num_onehot;
    logic [NUM_SRC-1:0] clr_vec;
    logic [VEC_W-1:0]   ptr_after_num;
    logic               win_found;
    logic [VEC_W-1:0]   win_idx;
    int                 idx_int;

    assign rise     = src_irq & ~src_q_reg;
    assign eligible = pending_reg & ~irq_mask;

    // One-hot decode of the vector in flight, used to retire its pending bit.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
            assign num_onehot[gi] = (msi_num_reg == VEC_W'(gi));
        end
    endgenerate

    // Pointer moves just past the source that was served (or abandoned),
    // wrapping explicitly so non-power-of-two NUM_SRC works.
    assign ptr_after_num = (msi_num_reg == VEC_W'(NUM_SRC - 1)) ? '0
                                                                : msi_num_reg + VEC_W'(1);

    // Round-robin search: first eligible index at or above rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_int   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_int = int'(rr_ptr_reg) + k;
            if (idx_int >= NUM_SRC) begin
                idx_int = idx_int - NUM_SRC;
            end
            if (!win_found && eligible[idx_int]) begin
                win_found = 1'b1;
                win_idx   = idx_int[VEC_W-1:0];
            end
        end
    end

`ifdef PCIE_IRQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT);

    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic            timeout_err_reg, timeout_err_next;
    logic            wd_fire;
`endif

    always_comb begin
        state_next   = state_reg;
        msi_req_next = msi_req_reg;
        msi_num_next = msi_num_reg;
        rr_ptr_next  = rr_ptr_reg;
        clr_vec      = '0;
`ifdef PCIE_IRQ_TIMEOUT_EN
        wd_cnt_next  = wd_cnt_reg;
        wd_fire      = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (msi.msi_enable && win_found) begin
                    state_next   = ST_REQ;
                    msi_req_next = 1'b1;
                    msi_num_next = win_idx;
`ifdef PCIE_IRQ_TIMEOUT_EN
                    wd_cnt_next  = '0;
`endif
                end
            end
            ST_REQ: begin
                // Enable and mask are deliberately not looked at here: a
                // request is only ever retired by ack (or the watchdog).
                if (msi.msi_ack) begin
                    clr_vec      = num_onehot;
                    rr_ptr_next  = ptr_after_num;
                    msi_req_next = 1'b0;
                    state_next   = ST_GAP;
                end
`ifdef PCIE_IRQ_TIMEOUT_EN
                else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
                    // Abandon: pending bit stays set, move on to the next source.
                    wd_fire      = 1'b1;
                    rr_ptr_next  = ptr_after_num;
                    msi_req_next = 1'b0;
                    state_next   = ST_GAP;
                end else begin
                    wd_cnt_next  = wd_cnt_reg + WD_W'(1);
                end
`endif
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next   = ST_IDLE;
                msi_req_next = 1'b0;
            end
        endcase
    end

    // A new rise in the retire cycle wins over the clear.
    assign pending_next = (pending_reg & ~clr_vec) | rise;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_reg   <= ST_IDLE;
            src_q_reg   <= '0;
            pending_reg <= '0;
            rr_ptr_reg  <= '0;
            msi_req_reg <= 1'b0;
            msi_num_reg <= '0;
        end else begin
            state_reg   <= state_next;
            src_q_reg   <= src_irq;
            pending_reg <= pending_next;
            rr_ptr_reg  <= rr_ptr_next;
            msi_req_reg <= msi_req_next;
            msi_num_reg <= msi_num_next;
        end
    end

`ifdef PCIE_IRQ_TIMEOUT_EN
    always_comb begin
        timeout_err_next = timeout_err_reg;
        if (wd_fire) begin
            timeout_err_next = 1'b1;
        end else if (err_clr) begin
            timeout_err_next = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            wd_cnt_reg      <= wd_cnt_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    // No watchdog: the expression is constant 0 (TIMEOUT is never negative);
    // it only consumes err_clr and TIMEOUT, which have no function here.
    assign timeout_err = err_clr & (TIMEOUT < 0);
`endif

    assign msi.msi_req = msi_req_reg;
    assign msi.msi_num = msi_num_reg;
    assign pending     = pending_reg;

endmodule

// File: tb/tb_pcie_irq_scheduler.sv
// tb_pcie_irq_scheduler
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model of the scheduler.
module tb_pcie_irq_scheduler;
    localparam int NS = 4;
    localparam int VW = 2;
    localparam int TO = 16;

    logic          axi_aclk    = 1'b0;
    logic          axi_aresetn = 1'b1;
    logic [NS-1:0] src_irq     = '0;
    logic [NS-1:0] irq_mask    = '0;
    logic [NS-1:0] pending;
    logic          timeout_err;
    logic          err_clr     = 1'b0;

    pcie_irq_scheduler_if #(.VEC_W(VW)) msi_bus();

    pcie_irq_scheduler #(
        .NUM_SRC (NS),
        .VEC_W   (VW),
        .TIMEOUT (TO)
    ) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .src_irq     (src_irq),
        .irq_mask    (irq_mask),
        .msi         (msi_bus),
        .pending     (pending),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 axi_aclk = ~axi_aclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: pending events as a bit array, the pointer as an
    // integer, and the request described by "is one open, which vector, how
    // long has it been open, is the mandatory quiet cycle still due".
    bit m_pend[NS];
    bit m_srcq[NS];
    int m_ptr;
    bit m_open;
    bit m_quiet;
    int m_num;
    int m_age;
    bit m_terr;

    int   grant_num[$];
    int   grant_cyc[$];
    logic prev_req = 1'b0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [NS-1:0] m_pvec();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 1'b0;
            m_srcq[i] = 1'b0;
        end
        m_ptr   = 0;
        m_open  = 1'b0;
        m_quiet = 1'b0;
        m_num   = 0;
        m_age   = 0;
        m_terr  = 1'b0;
    endtask

    task automatic model_edge();
        bit rise[NS];
        bit abandon;
        int w;
        abandon = 1'b0;
        for (int i = 0; i < NS; i++) begin
            rise[i]   = src_irq[i] && !m_srcq[i];
            m_srcq[i] = src_irq[i];
        end
        if (m_open) begin
            if (msi_bus.msi_ack) begin
                m_pend[m_num] = 1'b0;
                m_ptr   = (m_num + 1) % NS;
                m_open  = 1'b0;
                m_quiet = 1'b1;
            end
`ifdef PCIE_IRQ_TIMEOUT_EN
            else if (m_age == TO) begin
                abandon = 1'b1;
                m_ptr   = (m_num + 1) % NS;
                m_open  = 1'b0;
                m_quiet = 1'b1;
            end
`endif
            else begin
                m_age++;
            end
        end else if (m_quiet) begin
            m_quiet = 1'b0;
        end else if (msi_bus.msi_enable) begin
            w = -1;
            for (int k = 0; k < NS; k++) begin
                int j;
                j = (m_ptr + k) % NS;
                if (w < 0 && m_pend[j] && !irq_mask[j]) w = j;
            end
            if (w >= 0) begin
                m_num  = w;
                m_open = 1'b1;
                m_age  = 1;
            end
        end
        if (abandon) m_terr = 1'b1;
        else if (err_clr) m_terr = 1'b0;
        for (int i = 0; i < NS; i++) if (rise[i]) m_pend[i] = 1'b1;
    endtask

    task automatic compare_all();
        check("msi_req", msi_bus.msi_req, m_open);
        check("msi_num", msi_bus.msi_num, m_num);
        check("pending", pending, m_pvec());
        check("timeout_err", timeout_err, m_terr);
    endtask

    task automatic step();
        @(posedge axi_aclk);
        if (axi_aresetn) model_edge();
        #1;
        cyc++;
        compare_all();
        if (msi_bus.msi_req === 1'b1 && prev_req !== 1'b1) begin
            grant_num.push_back(int'(msi_bus.msi_num));
            grant_cyc.push_back(cyc);
            $display("grant vec %0d cycle %0d", msi_bus.msi_num, cyc);
        end
        prev_req = msi_bus.msi_req;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_req(int budget);
        for (int i = 0; i < budget && msi_bus.msi_req !== 1'b1; i++) step();
        check("wait_req", msi_bus.msi_req, 1'b1);
    endtask

    task automatic do_reset();
        src_irq            = '0;
        err_clr            = 1'b0;
        msi_bus.msi_ack    = 1'b0;
        axi_aresetn        = 1'b0;
        model_reset();
        prev_req           = 1'b0;
        #1;
        compare_all();
        steps(2);
        axi_aresetn = 1'b1;
    endtask

    task automatic clear_grants();
        grant_num.delete();
        grant_cyc.delete();
    endtask

    int hi;

    initial begin
        msi_bus.msi_ack    = 1'b0;
        msi_bus.msi_enable = 1'b0;
        model_reset();
        #1;
        // Reset state
        do_reset();
        check("rst_req", msi_bus.msi_req, 1'b0);
        check("rst_pending", pending, 4'b0000);

        // Single event on source 2, ack three cycles after request
        msi_bus.msi_enable = 1'b1;
        steps(8);
        src_irq[2] = 1'b1;
        step();
        check("single_pend", pending, 4'b0100);
        src_irq = '0;
        step();
        check("single_req", msi_bus.msi_req, 1'b1);
        check("single_num", msi_bus.msi_num, 2'd2);
        steps(2);
        msi_bus.msi_ack = 1'b1;
        step();
        msi_bus.msi_ack = 1'b0;
        check("single_req_low", msi_bus.msi_req, 1'b0);
        check("single_pend_clr", pending, 4'b0000);
        steps(3);

        // Round-robin 0,1,3 with immediate acks, then 0 and 3 again
        do_reset();
        msi_bus.msi_enable = 1'b1;
        msi_bus.msi_ack    = 1'b1;
        clear_grants();
        src_irq = 4'b1011;
        step();
        src_irq = '0;
        steps(12);
        check("rr_count", grant_num.size(), 3);
        if (grant_num.size() == 3) begin
            check("rr_g0", grant_num[0], 0);
            check("rr_g1", grant_num[1], 1);
            check("rr_g2", grant_num[2], 3);
            check("rr_gap01", grant_cyc[1] - grant_cyc[0], 3);
            check("rr_gap12", grant_cyc[2] - grant_cyc[1], 3);
        end
        clear_grants();
        src_irq = 4'b1001;
        step();
        src_irq = '0;
        steps(10);
        check("rr2_count", grant_num.size(), 2);
        if (grant_num.size() == 2) begin
            check("rr2_g0", grant_num[0], 0);
            check("rr2_g1", grant_num[1], 3);
        end

        // Mask and enable
        do_reset();
        msi_bus.msi_enable = 1'b1;
        msi_bus.msi_ack    = 1'b1;
        irq_mask = 4'b0010;
        clear_grants();
        src_irq = 4'b0110;
        step();
        src_irq = '0;
        steps(10);
        check("mask_count", grant_num.size(), 1);
        if (grant_num.size() == 1) check("mask_g0", grant_num[0], 2);
        check("mask_pend", pending, 4'b0010);
        irq_mask = '0;
        clear_grants();
        steps(6);
        check("unmask_count", grant_num.size(), 1);
        if (grant_num.size() == 1) check("unmask_g0", grant_num[0], 1);
        msi_bus.msi_enable = 1'b0;
        src_irq = 4'b0001;
        step();
        src_irq = '0;
        steps(6);
        check("en_off_req", msi_bus.msi_req, 1'b0);
        msi_bus.msi_enable = 1'b1;
        step();
        check("en_on_req", msi_bus.msi_req, 1'b1);
        steps(3);
        msi_bus.msi_ack = 1'b0;

        // Collision: new rise on src 3 during the ack of vector 3
        do_reset();
        msi_bus.msi_enable = 1'b1;
        src_irq[3] = 1'b1;
        step();
        src_irq = '0;
        step();
        check("col_num", msi_bus.msi_num, 2'd3);
        step();
        msi_bus.msi_ack = 1'b1;
        src_irq[3] = 1'b1;
        step();
        msi_bus.msi_ack = 1'b0;
        src_irq = '0;
        check("col_pend3", pending[3], 1'b1);
        check("col_req_low", msi_bus.msi_req, 1'b0);
        steps(2);
        check("col_rereq", msi_bus.msi_req, 1'b1);
        check("col_renum", msi_bus.msi_num, 2'd3);
        msi_bus.msi_ack = 1'b1;
        step();
        msi_bus.msi_ack = 1'b0;

        // Unacknowledged request
        do_reset();
        msi_bus.msi_enable = 1'b1;
        src_irq = 4'b0110;
        step();
        src_irq = '0;
        step();
        check("wd_num", msi_bus.msi_num, 2'd1);
        hi = 1;
        for (int k = 0; k < 39; k++) begin
            step();
            if (msi_bus.msi_req === 1'b1) hi++;
            else break;
        end
`ifdef PCIE_IRQ_TIMEOUT_EN
        check("wd_high_cycles", hi, TO);
        check("wd_err", timeout_err, 1'b1);
        check("wd_pend1", pending[1], 1'b1);
        steps(2);
        check("wd_next_num", msi_bus.msi_num, 2'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("wd_err_clr", timeout_err, 1'b0);
`else
        check("nowd_high_cycles", hi, 40);
        check("nowd_err", timeout_err, 1'b0);
`endif
        msi_bus.msi_ack = 1'b1;
        step();
        msi_bus.msi_ack = 1'b0;
        steps(3);

        // Asynchronous reset while a request is outstanding
        src_irq[0] = 1'b1;
        step();
        src_irq = '0;
        wait_req(12);
        axi_aresetn = 1'b0;
        model_reset();
        prev_req = 1'b0;
        #1;
        check("arst_req", msi_bus.msi_req, 1'b0);
        check("arst_pend", pending, 4'b0000);
        check("arst_err", timeout_err, 1'b0);
        steps(2);
        axi_aresetn = 1'b1;
        steps(6);
        check("arst_idle_req", msi_bus.msi_req, 1'b0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            src_irq            = NS'($urandom_range(0, (1 << NS) - 1));
            if ($urandom_range(0, 49) == 0) irq_mask = NS'($urandom_range(0, (1 << NS) - 1));
            msi_bus.msi_enable = ($urandom_range(0, 9) != 0);
            msi_bus.msi_ack    = ($urandom_range(0, 9) < 2);
            err_clr            = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
